// File: rtl/bictr_sched_pkg.sv
// Shared types and sizing helpers for the bictr_job_sched counter scheduler.
package bictr_sched_pkg;

  localparam int CTR_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  // Watchdog counter runs 0..cycles-1 inside RUN.
  function automatic int wdog_w(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bictr_job_sched_if.sv
// Requester-side and counter-side pins of the job scheduler, bundled.
interface bictr_job_sched_if
  import bictr_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = CTR_W
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_data;
  logic [NREQ*W-1:0] req_count_to;
  logic [NREQ-1:0]   req_up_dn;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   done;
  logic [NREQ-1:0]   err;
  logic              busy;
  logic [W-1:0]      ctr_data;
  logic              ctr_up_dn;
  logic              ctr_load;
  logic              ctr_cen;
  logic [W-1:0]      ctr_count_to;
  logic              ctr_tercnt;

  modport slave (
    input  req, req_data, req_count_to, req_up_dn, ctr_tercnt,
    output gnt, done, err, busy, ctr_data, ctr_up_dn, ctr_load, ctr_cen, ctr_count_to
  );

  modport master (
    output req, req_data, req_count_to, req_up_dn, ctr_tercnt,
    input  gnt, done, err, busy, ctr_data, ctr_up_dn, ctr_load, ctr_cen, ctr_count_to
  );
endinterface

// File: rtl/bictr_rr_arb.sv
// Round-robin arbiter: picks the first request at or after (last owner + 1) mod NREQ.
module bictr_rr_arb
  import bictr_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic                     advance,
  output logic [NREQ-1:0]          gnt,
  output logic [idx_w(NREQ)-1:0]   owner,
  output logic                     any
);
  localparam int IW = idx_w(NREQ);

  logic [IW-1:0] last;

  // Reset to NREQ-1 so requester 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (reset)        last <= IW'(NREQ - 1);
    else if (advance) last <= owner;
  end

  always_comb begin
    int idx;
    idx   = 0;
    gnt   = '0;
    owner = '0;
    any   = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = int'(last) + i;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!any && req[idx]) begin
        any   = 1'b1;
        owner = IW'(idx);
      end
    end
    if (any) gnt[owner] = 1'b1;
  end
endmodule

// File: rtl/bictr_job_sched.sv
// Time-shares one up/down counter among NREQ requesters as a load/count/done job.
// Optional watchdog abort in RUN: define BICTR_SCHED_WDOG_EN.
module bictr_job_sched
  import bictr_sched_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int W           = CTR_W,
  parameter int WDOG_CYCLES = 20
) (
  input  logic              clk,
  input  logic              reset,
  bictr_job_sched_if.slave  bus
);
  localparam int IW = idx_w(NREQ);

  state_t            state;
  logic              job_dir;
  logic [NREQ-1:0]   arb_gnt;
  logic [IW-1:0]     arb_owner;
  logic              arb_any;
  logic              advance;
  logic              wdog_hit;

  assign advance = (state == IDLE) && arb_any;

  bictr_rr_arb #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (bus.req),
    .advance (advance),
    .gnt     (arb_gnt),
    .owner   (arb_owner),
    .any     (arb_any)
  );

`ifdef BICTR_SCHED_WDOG_EN
  localparam int WW = wdog_w(WDOG_CYCLES);
  logic [WW-1:0] wdog_cnt;

  always_ff @(posedge clk) begin
    if (reset || state != RUN) wdog_cnt <= '0;
    else                       wdog_cnt <= wdog_cnt + 1'b1;
  end

  assign wdog_hit = (state == RUN) && (wdog_cnt == WW'(WDOG_CYCLES - 1));
`else
  logic unused_cfg;
  assign unused_cfg = (WDOG_CYCLES != 0);
  assign wdog_hit   = 1'b0;
`endif

  // cen must drop in the same cycle tercnt rises so the counter parks on count_to.
  assign bus.ctr_cen = (state == LOAD) ||
                       ((state == RUN) && !bus.ctr_tercnt && !wdog_hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= IDLE;
      bus.gnt          <= '0;
      bus.done         <= '0;
      bus.err          <= '0;
      bus.busy         <= 1'b0;
      bus.ctr_data     <= '0;
      bus.ctr_up_dn    <= 1'b0;
      bus.ctr_load     <= 1'b0;
      bus.ctr_count_to <= '0;
    end else begin
      bus.done <= '0;
      bus.err  <= '0;
      case (state)
        IDLE: begin
          if (arb_any) begin
            state            <= LOAD;
            bus.gnt          <= arb_gnt;
            bus.busy         <= 1'b1;
            bus.ctr_data     <= bus.req_data[arb_owner*W +: W];
            bus.ctr_count_to <= bus.req_count_to[arb_owner*W +: W];
            job_dir          <= bus.req_up_dn[arb_owner];
            bus.ctr_load     <= 1'b1;
            bus.ctr_up_dn    <= 1'b0;
          end
        end
        LOAD: begin
          state         <= RUN;
          bus.ctr_load  <= 1'b0;
          bus.ctr_up_dn <= job_dir;
        end
        RUN: begin
          if (bus.ctr_tercnt) begin
            state    <= DONE;
            bus.done <= bus.gnt;
          end else if (wdog_hit) begin
            state   <= DONE;
            bus.err <= bus.gnt;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.gnt  <= '0;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bictr_job_sched.sv
// Directed bench for bictr_job_sched with a behavioural model of the shared counter.
module tb_bictr_job_sched;
  logic clk = 1'b0;
  logic reset;
  logic [3:0] cnt = 4'd0;
  logic kill = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bictr_job_sched_if #(.NREQ(4), .W(4)) bus ();

  bictr_job_sched #(.NREQ(4), .W(4), .WDOG_CYCLES(20)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Counter model: loads when load=1 and up_dn=0, otherwise steps mod 16.
  always @(posedge clk) begin
    if (bus.ctr_cen) begin
      if (bus.ctr_load && !bus.ctr_up_dn) cnt <= bus.ctr_data;
      else if (bus.ctr_up_dn)             cnt <= cnt + 4'd1;
      else                                cnt <= cnt - 4'd1;
    end
  end
  assign bus.ctr_tercnt = !kill && (cnt == bus.ctr_count_to);

  task automatic chk(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [3:0] s, input logic [3:0] t, input logic d);
    bus.req_data[idx*4 +: 4]     = s;
    bus.req_count_to[idx*4 +: 4] = t;
    bus.req_up_dn[idx]           = d;
    bus.req[idx]                 = 1'b1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"},   int'(bus.gnt), 0);
    chk({tag, "_done"},  int'(bus.done), 0);
    chk({tag, "_err"},   int'(bus.err), 0);
    chk({tag, "_busy"},  int'(bus.busy), 0);
    chk({tag, "_load"},  int'(bus.ctr_load), 0);
    chk({tag, "_cen"},   int'(bus.ctr_cen), 0);
    chk({tag, "_updn"},  int'(bus.ctr_up_dn), 0);
    chk({tag, "_data"},  int'(bus.ctr_data), 0);
    chk({tag, "_cto"},   int'(bus.ctr_count_to), 0);
  endtask

  // Request in cycle 1; done expected in cycle exp_lat.
  task automatic run_job(input string tag, input int idx, input logic [3:0] s,
                         input logic [3:0] t, input logic d, input int exp_steps,
                         input int exp_lat);
    int n = 1;
    int steps = 0;
    int loads = 0;
    int first_val = -1;
    bit prev_load = 1'b0;
    bit got = 1'b0;
    set_req(idx, s, t, d);
    while (!got && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (prev_load) first_val = int'(cnt);
      prev_load = bus.ctr_load;
      if (bus.ctr_load) begin
        loads++;
        chk({tag, "_ldata"}, int'(bus.ctr_data), int'(s));
        chk({tag, "_lupdn"}, int'(bus.ctr_up_dn), 0);
        chk({tag, "_lgnt"},  int'(bus.gnt), 1 << idx);
      end else if (bus.ctr_cen) begin
        steps++;
      end
      if (bus.done != 0 || bus.err != 0) begin
        got = 1'b1;
        chk({tag, "_done"},  int'(bus.done), 1 << idx);
        chk({tag, "_err"},   int'(bus.err), 0);
        chk({tag, "_gnt"},   int'(bus.gnt), 1 << idx);
        chk({tag, "_lat"},   n, exp_lat);
        chk({tag, "_steps"}, steps, exp_steps);
        chk({tag, "_final"}, int'(cnt), int'(t));
        chk({tag, "_first"}, first_val, int'(s));
        chk({tag, "_loads"}, loads, 1);
        bus.req[idx] = 1'b0;
      end
    end
    if (!got) begin
      chk({tag, "_timeout"}, 0, 1);
      bus.req = '0;
    end
    @(posedge clk); #1;
    chk({tag, "_busy_after"}, int'(bus.busy), 0);
    chk({tag, "_gnt_after"},  int'(bus.gnt), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    int k;
    int multi;
    int cyc;
    int who;
    bus.req          = '0;
    bus.req_data     = '0;
    bus.req_count_to = '0;
    bus.req_up_dn    = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("rst");
    reset = 1'b0;
    @(posedge clk); #1;
    chk_idle("post_rst");

    run_job("up", 0, 4'd3, 4'd9, 1'b1, 6, 10);
    run_job("dnwrap", 0, 4'd2, 4'd14, 1'b0, 4, 8);
    run_job("eq", 0, 4'd5, 4'd5, 1'b1, 0, 4);

    // Reset in the middle of a long job.
    set_req(2, 4'd0, 4'd15, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("mid_busy", int'(bus.busy), 1);
    chk("mid_gnt",  int'(bus.gnt), 4);
    chk("mid_cen",  int'(bus.ctr_cen), 1);
    reset   = 1'b1;
    bus.req = '0;
    @(posedge clk); #1;
    chk_idle("midrst");
    reset = 1'b0;
    run_job("stale", 1, 4'd7, 4'd4, 1'b0, 3, 7);

    // All four requesters held: round-robin order from a fresh reset.
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, 4'(i), 4'(i + 2), 1'b1);
    k = 0;
    multi = 0;
    cyc = 0;
    while (k < 5 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if ($countones(bus.gnt) > 1 || $countones(bus.done) > 1) multi++;
      if (bus.done != 0) begin
        who = -1;
        for (int b = 0; b < 4; b++) if (bus.done[b]) who = b;
        chk("rr_owner", who, order[k]);
        chk("rr_done_gnt", int'(bus.done), int'(bus.gnt));
        k++;
        if (k == 5) bus.req = '0;
      end
    end
    chk("rr_jobs", k, 5);
    chk("rr_onehot", multi, 0);
    @(posedge clk); #1;
    chk("rr_busy_after", int'(bus.busy), 0);

`ifdef BICTR_SCHED_WDOG_EN
    begin
      int n = 1;
      int steps = 0;
      bit got = 1'b0;
      kill = 1'b1;
      set_req(3, 4'd0, 4'd3, 1'b1);
      while (!got && n < 60) begin
        @(posedge clk); #1;
        n++;
        if (!bus.ctr_load && bus.ctr_cen) steps++;
        if (bus.done != 0 || bus.err != 0) begin
          got = 1'b1;
          chk("wdog_err",  int'(bus.err), 8);
          chk("wdog_done", int'(bus.done), 0);
          chk("wdog_lat",  n, 23);
          chk("wdog_cen",  steps, 19);
          bus.req = '0;
        end
      end
      if (!got) begin
        chk("wdog_timeout", 0, 1);
        bus.req = '0;
      end
      kill = 1'b0;
      @(posedge clk); #1;
      chk("wdog_busy_after", int'(bus.busy), 0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
